inst_mem_pipe: RTL and testbench

INST_MEM_PIPE -- requirements
Module: inst_mem_pipe

---
 rtl/inst_mem_pipe.sv | 90 +++++++++
 tb/tb_inst_mem_pipe.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/inst_mem_pipe.sv
// Instruction memory with a one-deep registered fetch response and a
// program-load write port; misaligned and out-of-range fetches fault.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     fetch request handshake, req_addr = byte PC
//   rsp_valid/ready     response handshake, rsp_inst + rsp_fault
//                       (00 ok, 01 misaligned, 10 out of range)
//   flush               drop the pending response, block fetch this cycle
//   ld_en/addr/data     word-indexed program-load write
module inst_mem_pipe #(
    parameter int                DEPTH_LOG2 = 12,
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_inst,
    output logic [1:0]            rsp_fault,
    input  logic                  flush,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [DATA_W-1:0]     ld_data
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [1:0] F_OK      = 2'b00;
    localparam logic [1:0] F_MISALGN = 2'b01;
    localparam logic [1:0] F_RANGE   = 2'b10;

    logic [DATA_W-1:0]     mem [DEPTH];

    logic                  fire;
    logic                  misalign;
    logic                  out_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]            fault_d;

    // Loads and flushes steal the request slot; otherwise fetch whenever
    // the response register is empty or being drained this cycle.
    assign req_ready = !ld_en && !flush && (!rsp_valid || rsp_ready);
    assign fire      = req_valid && req_ready;

    always_comb begin
        idx       = req_addr[DEPTH_LOG2+1:2];
        misalign  = |req_addr[1:0];
        out_range = |req_addr[31:DEPTH_LOG2+2];
        fault_d   = F_OK;
        // Misalignment outranks the range check.
        if (misalign) begin
            fault_d = F_MISALGN;
        end else if (out_range) begin
            fault_d = F_RANGE;
        end
    end

    // Memory is never reset; a load never coincides with a fire, so the
    // write lands before any later fetch can read it.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_inst  <= '0;
            rsp_fault <= F_OK;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else if (fire) begin
            rsp_valid <= 1'b1;
            rsp_fault <= fault_d;
            if (fault_d == F_OK) begin
                rsp_inst <= mem[idx];
            end else begin
                rsp_inst <= NOP_WORD;
            end
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Directed bench for inst_mem_pipe: load, fetch, faults, stall,
// back-to-back fetch, flush and asynchronous reset.
module tb_inst_mem_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_inst;
    logic [1:0]  rsp_fault;
    logic        flush;
    logic        ld_en;
    logic [11:0] ld_addr;
    logic [31:0] ld_data;

    int n_cmp = 0;
    int n_err = 0;

    inst_mem_pipe #(
        .DEPTH_LOG2(12),
        .DATA_W    (32),
        .NOP_WORD  (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_inst (rsp_inst),
        .rsp_fault(rsp_fault),
        .flush    (flush),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr,
                         input logic [31:0] inst, input logic [1:0] flt);
        req_addr = addr;
        tick();
        chk({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
        chk({tag, "_inst"}, rsp_inst, inst);
        chk({tag, "_fault"}, {30'b0, rsp_fault}, {30'b0, flt});
    endtask

    initial begin
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        flush     = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_inst", rsp_inst, 32'd0);
        chk("rst_fault", {30'b0, rsp_fault}, 32'd0);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);

        @(negedge clk);
        rst_n     = 1'b1;
        ld_en     = 1'b1;
        ld_addr   = 12'd5;
        ld_data   = 32'h2402_0001;
        req_valid = 1'b1;
        req_addr  = 32'h14;
        rsp_ready = 1'b1;
        #1 chk("ld_ready", {31'b0, req_ready}, 32'd0);
        tick();
        chk("ld_nofire", {31'b0, rsp_valid}, 32'd0);

        req_valid = 1'b0;
        ld_addr = 12'd0; ld_data = 32'hA000_0000; tick();
        ld_addr = 12'd1; ld_data = 32'hA000_0001; tick();
        ld_addr = 12'd2; ld_data = 32'hA000_0002; tick();

        ld_en     = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h8;
        #1 chk("post_ld_ready", {31'b0, req_ready}, 32'd1);
        fetch("fresh_ld", 32'h8, 32'hA000_0002, 2'b00);
        fetch("a14", 32'h14, 32'h2402_0001, 2'b00);
        fetch("mis16", 32'h16, 32'h0, 2'b01);
        fetch("oor", 32'h0001_0000, 32'h0, 2'b10);
        fetch("mis_oor", 32'h0001_0002, 32'h0, 2'b01);
        fetch("seq0", 32'h0, 32'hA000_0000, 2'b00);
        fetch("seq4", 32'h4, 32'hA000_0001, 2'b00);
        fetch("seq8", 32'h8, 32'hA000_0002, 2'b00);

        req_valid = 1'b0;
        tick();
        chk("drain_valid", {31'b0, rsp_valid}, 32'd0);

        req_valid = 1'b1;
        rsp_ready = 1'b0;
        fetch("stall_first", 32'h0, 32'hA000_0000, 2'b00);
        req_addr = 32'h4;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_ready", {31'b0, req_ready}, 32'd0);
            tick();
            chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
            chk("stall_inst", rsp_inst, 32'hA000_0000);
        end

        ld_en   = 1'b1;
        ld_addr = 12'd0;
        ld_data = 32'hB0B0_0000;
        tick();
        chk("ld_hold_valid", {31'b0, rsp_valid}, 32'd1);
        chk("ld_hold_inst", rsp_inst, 32'hA000_0000);

        ld_en     = 1'b0;
        rsp_ready = 1'b1;
        #1 chk("release_ready", {31'b0, req_ready}, 32'd1);
        fetch("release", 32'h4, 32'hA000_0001, 2'b00);

        flush     = 1'b1;
        req_addr  = 32'h8;
        rsp_ready = 1'b0;
        #1 chk("flush_ready", {31'b0, req_ready}, 32'd0);
        tick();
        chk("flush_valid", {31'b0, rsp_valid}, 32'd0);
        flush = 1'b0;

        fetch("pre_rst", 32'h4, 32'hA000_0001, 2'b00);
        tick();
        chk("pre_rst_hold", rsp_inst, 32'hA000_0001);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("arst_inst", rsp_inst, 32'd0);
        chk("arst_fault", {30'b0, rsp_fault}, 32'd0);
        tick();
        chk("rst_hold_valid", {31'b0, rsp_valid}, 32'd0);

        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        fetch("post_rst", 32'h0, 32'hB0B0_0000, 2'b00);

        req_valid = 1'b0;
        tick();
        chk("end_valid", {31'b0, rsp_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
